lsu_mem: RTL and testbench

Parametrised data-memory access unit for the NPC core. It replaces the purely combinational load/store memory path with a valid/ready request/response interface, programmable wait-state latency, byte-lane store strobes, aligned load extraction with sign/zero extension, and an error response for misaligned or illegal accesses. It sits between the EXU/LSU stage and the DPI-C `pmem_read`/`pmem_write` simulation memory. Instruction fetch stays outside this block.

---
 rtl/lsu_mem_pkg.sv | 24 ++
 rtl/lsu_mem_align.sv | 62 ++++++
 rtl/lsu_mem.sv | 144 ++++++++++++++
 tb/tb_lsu_mem.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_pkg.sv
// Shared constants for the load/store memory unit: RV32 funct3 codes, bus width,
// reset level and FSM state encoding.
package lsu_mem_pkg;

  localparam int unsigned RegBus = 32;
  localparam logic RST_VAL = 1'b0;

  localparam logic [2:0] Funct3Lb  = 3'b000;
  localparam logic [2:0] Funct3Lh  = 3'b001;
  localparam logic [2:0] Funct3Lw  = 3'b010;
  localparam logic [2:0] Funct3Lbu = 3'b100;
  localparam logic [2:0] Funct3Lhu = 3'b101;

  localparam logic [2:0] Funct3Sb  = 3'b000;
  localparam logic [2:0] Funct3Sh  = 3'b001;
  localparam logic [2:0] Funct3Sw  = 3'b010;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } lsu_state_e;

endpackage

// File: rtl/lsu_mem_align.sv
// Byte-lane steering for the LSU: store data/strobe placement, load extraction with
// sign/zero extension, and legality of funct3/alignment. Purely combinational.
module lsu_mem_align
  import lsu_mem_pkg::*;
(
  input  logic [2:0]        funct3_i,
  input  logic              wen_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [RegBus-1:0] wdata_i,
  input  logic [RegBus-1:0] rdata_i,
  output logic [RegBus-1:0] wdata_o,
  output logic [7:0]        wmask_o,
  output logic [RegBus-1:0] rdata_o,
  output logic              illegal_o
);

  logic [4:0]        shamt;
  logic [RegBus-1:0] rshift;

  always_comb begin
    shamt     = {addr_lo_i, 3'b000};
    rshift    = rdata_i >> shamt;
    wdata_o   = wdata_i << shamt;
    wmask_o   = 8'h00;
    rdata_o   = '0;
    illegal_o = 1'b0;
    if (wen_i) begin
      case (funct3_i)
        Funct3Sb: wmask_o = 8'h1 << addr_lo_i;
        Funct3Sh: begin
          wmask_o   = 8'h3 << addr_lo_i;
          illegal_o = addr_lo_i[0];
        end
        Funct3Sw: begin
          wmask_o   = 8'hF;
          illegal_o = |addr_lo_i;
        end
        default:  illegal_o = 1'b1;
      endcase
    end else begin
      case (funct3_i)
        Funct3Lb:  rdata_o = {{24{rshift[7]}}, rshift[7:0]};
        Funct3Lbu: rdata_o = {24'h0, rshift[7:0]};
        Funct3Lh: begin
          rdata_o   = {{16{rshift[15]}}, rshift[15:0]};
          illegal_o = addr_lo_i[0];
        end
        Funct3Lhu: begin
          rdata_o   = {16'h0, rshift[15:0]};
          illegal_o = addr_lo_i[0];
        end
        Funct3Lw: begin
          rdata_o   = rdata_i;
          illegal_o = |addr_lo_i;
        end
        default:   illegal_o = 1'b1;
      endcase
    end
    if (illegal_o) wmask_o = 8'h00;
  end

endmodule

// File: rtl/lsu_mem.sv
// Data-memory access unit: valid/ready request/response with programmable wait states.
// The memory port (mem_*) fires for exactly one cycle per legal request; memory acts on that edge.
module lsu_mem
  import lsu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_valid,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam bit         ZeroLat = (LATENCY == 0);
  localparam logic [3:0] CntInit = ZeroLat ? 4'd0 : 4'(LATENCY - 1);

  lsu_state_e        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              wen_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              accept;

  logic              idle;
  logic              cur_wen;
  logic [2:0]        cur_funct3;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_wdata;
  logic [DATA_W-1:0] align_rdata;
  logic              illegal;

  // In IDLE the live request drives the datapath so a zero-latency access can use it directly.
  assign idle       = (state_q == StIdle);
  assign cur_wen    = idle ? req_wen    : wen_q;
  assign cur_funct3 = idle ? req_funct3 : funct3_q;
  assign cur_addr   = idle ? req_addr   : addr_q;
  assign cur_wdata  = idle ? req_wdata  : wdata_q;

  lsu_mem_align u_align (
    .funct3_i  (cur_funct3),
    .wen_i     (cur_wen),
    .addr_lo_i (cur_addr[1:0]),
    .wdata_i   (cur_wdata),
    .rdata_i   (mem_rdata),
    .wdata_o   (mem_wdata),
    .wmask_o   (mem_wmask),
    .rdata_o   (align_rdata),
    .illegal_o (illegal)
  );

  assign mem_wen    = cur_wen;
  assign mem_addr   = {cur_addr[ADDR_W-1:2], 2'b00};
  assign req_ready  = idle;
  assign resp_valid = (state_q == StResp);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    accept    = 1'b0;
    mem_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          accept = 1'b1;
          if (illegal) begin
            state_d = StResp;
            rdata_d = '0;
            err_d   = 1'b1;
          end else if (ZeroLat) begin
            mem_valid = 1'b1;
            state_d   = StResp;
            rdata_d   = req_wen ? '0 : align_rdata;
            err_d     = 1'b0;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          mem_valid = 1'b1;
          state_d   = StResp;
          rdata_d   = wen_q ? '0 : align_rdata;
          err_d     = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (resp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_VAL) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      wen_q    <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        wen_q    <= req_wen;
        funct3_q <= req_funct3;
        addr_q   <= req_addr;
        wdata_q  <= req_wdata;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem.sv
// Randomized bench for lsu_mem: three instances (LATENCY 0, 2, 4) share one word-array memory;
// responses are compared against a byte-level reference model of that memory.
module tb_lsu_mem;

  localparam int NInst = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid  [NInst];
  logic        req_ready  [NInst];
  logic        req_wen    [NInst];
  logic [2:0]  req_funct3 [NInst];
  logic [31:0] req_addr   [NInst];
  logic [31:0] req_wdata  [NInst];
  logic        resp_valid [NInst];
  logic        resp_ready [NInst];
  logic [31:0] resp_rdata [NInst];
  logic        resp_err   [NInst];
  logic        mem_valid  [NInst];
  logic        mem_wen    [NInst];
  logic [31:0] mem_addr   [NInst];
  logic [31:0] mem_wdata  [NInst];
  logic [7:0]  mem_wmask  [NInst];
  logic [31:0] mem_rdata  [NInst];

  logic [31:0] mem [16];
  logic [31:0] ref_mem [16];
  int          dpi_calls = 0;
  logic [31:0] last_addr, last_wdata;
  logic [7:0]  last_wmask;
  logic        pre_en = 1'b0;
  logic [3:0]  pre_idx;
  logic [31:0] pre_val;

  int checks = 0;
  int failures = 0;

  for (genvar g = 0; g < NInst; g++) begin : g_dut
    lsu_mem #(
      .ADDR_W  (32),
      .DATA_W  (32),
      .LATENCY (2 * g)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_wen    (req_wen[g]),
      .req_funct3 (req_funct3[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_rdata (resp_rdata[g]),
      .resp_err   (resp_err[g]),
      .mem_valid  (mem_valid[g]),
      .mem_wen    (mem_wen[g]),
      .mem_addr   (mem_addr[g]),
      .mem_wdata  (mem_wdata[g]),
      .mem_wmask  (mem_wmask[g]),
      .mem_rdata  (mem_rdata[g])
    );
    assign mem_rdata[g] = mem[mem_addr[g][5:2]];
  end

  // Stand-in for pmem_read/pmem_write: acts on the clock edge of each memory strobe.
  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    for (int k = 0; k < NInst; k++) begin
      if (rst && mem_valid[k]) begin
        dpi_calls  <= dpi_calls + 1;
        last_addr  <= mem_addr[k];
        last_wdata <= mem_wdata[k];
        last_wmask <= mem_wmask[k];
        if (mem_wen[k]) begin
          for (int b = 0; b < 4; b++) begin
            if (mem_wmask[k][b]) mem[mem_addr[k][5:2]][8*b +: 8] <= mem_wdata[k][8*b +: 8];
          end
        end
      end
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int access_size(input logic wen, input logic [2:0] f3);
    if (wen) begin
      case (f3)
        3'd0:    return 1;
        3'd1:    return 2;
        3'd2:    return 4;
        default: return 0;
      endcase
    end
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] addr,
                                             input int size);
    logic [31:0] v;
    int bits;
    bits = 8 * size;
    v = ref_mem[addr[5:2]] >> (8 * int'(addr[1:0]));
    if (size < 4) begin
      v = v & ((32'd1 << bits) - 32'd1);
      if (!f3[2] && v[bits-1]) v = v - (32'd1 << bits);
    end
    return v;
  endfunction

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    pre_en  = 1'b1;
    pre_idx = 4'(idx);
    pre_val = val;
    ref_mem[idx] = val;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic do_txn(input int k, input logic wen, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd, input int stall);
    int size, cycles, calls0, lat;
    logic legal;
    logic [31:0] exp_rdata;
    size  = access_size(wen, f3);
    legal = (size != 0) && ((addr % size) == 0);
    lat   = 2 * k;
    exp_rdata = 32'h0;
    if (legal && !wen) exp_rdata = load_value(f3, addr, size);
    @(negedge clk);
    calls0 = dpi_calls;
    check_val("req_ready_idle", 32'(req_ready[k]), 32'h1);
    req_valid[k]  = 1'b1;
    req_wen[k]    = wen;
    req_funct3[k] = f3;
    req_addr[k]   = addr;
    req_wdata[k]  = wd;
    @(negedge clk);
    req_valid[k]  = 1'b0;
    req_wen[k]    = 1'($urandom);
    req_funct3[k] = 3'($urandom);
    req_addr[k]   = $urandom;
    req_wdata[k]  = $urandom;
    cycles = 1;
    while (!resp_valid[k] && cycles < 40) begin
      @(negedge clk);
      cycles++;
    end
    check_val("latency", 32'(cycles), legal ? 32'(lat + 1) : 32'd1);
    check_val("rdata", resp_rdata[k], exp_rdata);
    check_val("err", 32'(resp_err[k]), legal ? 32'd0 : 32'd1);
    check_val("dpi_calls", 32'(dpi_calls - calls0), legal ? 32'd1 : 32'd0);
    if (legal) check_val("dpi_addr", last_addr, {addr[31:2], 2'b00});
    if (legal && wen) begin
      for (int b = 0; b < size; b++) ref_mem[addr[5:2]][8*(int'(addr[1:0]) + b) +: 8] = wd[8*b +: 8];
    end
    for (int i = 0; i < stall; i++) begin
      req_valid[k]  = 1'b1;
      req_wen[k]    = 1'b0;
      req_funct3[k] = 3'b010;
      req_addr[k]   = 32'h8000_0000;
      @(negedge clk);
      check_val("stall_valid", 32'(resp_valid[k]), 32'h1);
      check_val("stall_rdata", resp_rdata[k], exp_rdata);
      check_val("stall_err", 32'(resp_err[k]), legal ? 32'd0 : 32'd1);
      check_val("stall_req_ready", 32'(req_ready[k]), 32'h0);
    end
    req_valid[k]  = 1'b0;
    resp_ready[k] = 1'b1;
    @(negedge clk);
    resp_ready[k] = 1'b0;
    check_val("resp_released", 32'(resp_valid[k]), 32'h0);
    check_val("no_extra_call", 32'(dpi_calls - calls0), legal ? 32'd1 : 32'd0);
  endtask

  initial begin
    int calls0, sel, size;
    logic [31:0] old, a, w;
    logic [2:0] f3;
    logic wen;
    logic [2:0] load_f3 [5];
    load_f3[0] = 3'd0; load_f3[1] = 3'd1; load_f3[2] = 3'd2; load_f3[3] = 3'd4; load_f3[4] = 3'd5;
    for (int k = 0; k < NInst; k++) begin
      req_valid[k] = 1'b0; req_wen[k] = 1'b0; req_funct3[k] = 3'b0;
      req_addr[k] = 32'h0; req_wdata[k] = 32'h0; resp_ready[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < NInst; k++) begin
      check_val("rst_req_ready", 32'(req_ready[k]), 32'h1);
      check_val("rst_resp_valid", 32'(resp_valid[k]), 32'h0);
      check_val("rst_rdata", resp_rdata[k], 32'h0);
      check_val("rst_err", 32'(resp_err[k]), 32'h0);
    end
    rst = 1'b1;
    for (int i = 0; i < 16; i++) preload(i, $urandom);

    preload(1, 32'hDEAD_BEEF);
    do_txn(1, 1'b0, 3'b010, 32'h8000_0004, 32'h0, 0);
    preload(0, 32'h8765_4321);
    do_txn(0, 1'b0, 3'b101, 32'h8000_0002, 32'h0, 0);
    do_txn(1, 1'b1, 3'b000, 32'h8000_0003, 32'h1234_56AB, 0);
    check_val("sb_waddr", last_addr, 32'h8000_0000);
    check_val("sb_wdata", last_wdata, 32'hAB00_0000);
    check_val("sb_wmask", 32'(last_wmask), 32'h8);
    do_txn(1, 1'b0, 3'b100, 32'h8000_0003, 32'h0, 0);
    do_txn(0, 1'b0, 3'b000, 32'h8000_0003, 32'h0, 0);
    do_txn(2, 1'b0, 3'b001, 32'h8000_0001, 32'h0, 0);
    do_txn(2, 1'b1, 3'b010, 32'h8000_0002, 32'h5555_5555, 0);
    do_txn(1, 1'b0, 3'b011, 32'h8000_0000, 32'h0, 0);
    do_txn(1, 1'b0, 3'b010, 32'h8000_0004, 32'h0, 5);

    // Store killed by reset before its access edge must leave memory untouched.
    old = ref_mem[5];
    calls0 = dpi_calls;
    @(negedge clk);
    req_valid[2] = 1'b1; req_wen[2] = 1'b1; req_funct3[2] = 3'b010;
    req_addr[2] = 32'h8000_0014; req_wdata[2] = ~old;
    @(negedge clk);
    req_valid[2] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_val("arst_req_ready", 32'(req_ready[2]), 32'h1);
    check_val("arst_resp_valid", 32'(resp_valid[2]), 32'h0);
    check_val("arst_rdata", resp_rdata[2], 32'h0);
    check_val("arst_err", 32'(resp_err[2]), 32'h0);
    repeat (6) @(negedge clk);
    check_val("arst_no_write_call", 32'(dpi_calls - calls0), 32'h0);
    check_val("arst_mem_kept", mem[5], old);
    rst = 1'b1;
    do_txn(2, 1'b0, 3'b010, 32'h8000_0014, 32'h0, 0);

    for (int k = 0; k < NInst; k++) begin
      for (int n = 0; n < 40; n++) begin
        sel = int'($urandom_range(0, 9));
        wen = 1'($urandom);
        if (sel >= 8) f3 = 3'($urandom);
        else if (wen) f3 = 3'($urandom_range(0, 2));
        else f3 = load_f3[$urandom_range(0, 4)];
        a = 32'h8000_0000 + 32'($urandom_range(0, 63));
        size = access_size(wen, f3);
        if (sel < 6 && size != 0) a = a & ~(32'(size) - 32'd1);
        w = $urandom;
        do_txn(k, wen, f3, a, w, ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
